// File: rtl/mode_encoder.sv
// mode_encoder: re-encodes ALU opcodes (mode_a) into panel mode codes (mode_d) through a valid/ready FIFO.
// Define MODE_ENCODER_STATS_EN to add the saturating op_count push counter port.
module mode_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [3:0]       s_mode_a,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [3:0]       m_mode_d,
  output logic             m_is_logic,
`ifdef MODE_ENCODER_STATS_EN
  output logic [15:0]      op_count,
`endif
  output logic [CNT_W-1:0] level
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  logic [3:0]       r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_level;
  logic [3:0]       r_last;
  logic [3:0]       w_enc;
  logic [3:0]       w_head;
  logic             w_push;
  logic             w_pop;
  always_comb begin
    w_enc = 4'b0000;
    case (s_mode_a)
      4'b1000: w_enc = 4'b0000;
      4'b1001: w_enc = 4'b0001;
      4'b0110: w_enc = 4'b0010;
      4'b0111: w_enc = 4'b0011;
      4'b1010: w_enc = 4'b0100;
      4'b1011: w_enc = 4'b0101;
      4'b1110: w_enc = 4'b0110;
      4'b1111: w_enc = 4'b0111;
      4'b1100: w_enc = 4'b1000;
      4'b1101: w_enc = 4'b1001;
      4'b0000: w_enc = 4'b1010;
      4'b0001: w_enc = 4'b1011;
      4'b0010: w_enc = 4'b1100;
      4'b0011: w_enc = 4'b1101;
      4'b0100: w_enc = 4'b1110;
      4'b0101: w_enc = 4'b1111;
      default: w_enc = 4'b0000;
    endcase
  end
  assign s_ready    = r_level != FULL;
  assign m_valid    = r_level != '0;
  assign w_push     = s_valid & s_ready;
  assign w_pop      = m_valid & m_ready;
  assign w_head     = r_mem[r_rd_ptr];
  // when empty the output keeps showing the last head seen
  assign m_mode_d   = m_valid ? w_head : r_last;
  assign m_is_logic = m_mode_d >= 4'b1010;
  assign level      = r_level;
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_enc;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_last   <= 4'b0000;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (m_valid) r_last <= w_head;
      r_level <= r_level + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end
`ifdef MODE_ENCODER_STATS_EN
  logic [15:0] r_op_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_op_count <= 16'h0000;
    else if (w_push && r_op_count != 16'hFFFF) r_op_count <= r_op_count + 16'd1;
  end
  assign op_count = r_op_count;
`endif
endmodule
